// File: rtl/turn_ctrl_multi.sv
// Turn controller for a multi-player group-matching game: manual/timeout picks,
// match scoring with saturation, mismatch reveal pause and player rotation.
module turn_ctrl_multi #(
    parameter int NUM_PLAYERS  = 2,
    parameter int GROUP_SIZE   = 2,
    parameter int TURN_TICKS   = 15,
    parameter int PAUSE_CYCLES = 4,
    parameter int SCORE_W      = 4,
    localparam int PW = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1,
    localparam int TW = $clog2(TURN_TICKS + 1),
    localparam int GW = $clog2(GROUP_SIZE)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tick_i,
    input  logic                           btn_sel_i,
    input  logic                           pick_valid_i,
    input  logic                           auto_pick_valid_i,
    input  logic                           group_match_i,
    input  logic                           game_over_i,
    output logic                           pick_o,
    output logic                           auto_pick_o,
    output logic [GW-1:0]                  pick_idx_o,
    output logic                           match_found_o,
    output logic                           extra_turn_o,
    output logic                           start_pause_o,
    output logic                           end_turn_o,
    output logic [PW-1:0]                  player_o,
    output logic [TW-1:0]                  time_left_o,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores_o,
    output logic [1:0]                     state_o
);

    localparam int CW = (PAUSE_CYCLES > 2) ? $clog2(PAUSE_CYCLES) : 1;
    localparam int SW = NUM_PLAYERS * SCORE_W;

    typedef enum logic [1:0] {
        S_PICK  = 2'd0,
        S_PAUSE = 2'd1,
        S_OVER  = 2'd2,
        S_ILL   = 2'd3
    } state_t;

    state_t          state_q,  state_d;
    logic [PW-1:0]   player_q, player_d;
    logic [GW-1:0]   cnt_q,    cnt_d;
    logic [CW-1:0]   pause_q,  pause_d;
    logic [TW-1:0]   tl_q,     tl_d;
    logic [SW-1:0]   scores_q, scores_d;

    logic manual_ev;
    logic timeout_ev;
    logic auto_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_PICK;
            player_q <= '0;
            cnt_q    <= '0;
            pause_q  <= '0;
            tl_q     <= TW'(TURN_TICKS);
            scores_q <= '0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            cnt_q    <= cnt_d;
            pause_q  <= pause_d;
            tl_q     <= tl_d;
            scores_q <= scores_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        player_d      = player_q;
        cnt_d         = cnt_q;
        pause_d       = pause_q;
        tl_d          = tl_q;
        scores_d      = scores_q;
        pick_o        = 1'b0;
        auto_pick_o   = 1'b0;
        match_found_o = 1'b0;
        extra_turn_o  = 1'b0;
        start_pause_o = 1'b0;
        end_turn_o    = 1'b0;
        pick_idx_o    = cnt_q;

        manual_ev  = btn_sel_i & pick_valid_i;
        timeout_ev = tick_i & (tl_q == TW'(1));
        auto_ev    = timeout_ev & auto_pick_valid_i & ~manual_ev;

        if (game_over_i) begin
            state_d = S_OVER;
        end else begin
            case (state_q)
                S_PICK: begin
                    if (manual_ev || auto_ev) begin
                        pick_o      = manual_ev;
                        auto_pick_o = auto_ev;
                        tl_d        = TW'(TURN_TICKS);
                        if (cnt_q < GW'(GROUP_SIZE - 1)) begin
                            cnt_d = cnt_q + GW'(1);
                        end else if (group_match_i) begin
                            match_found_o = 1'b1;
                            extra_turn_o  = 1'b1;
                            cnt_d         = '0;
                            // Only the active player's slice moves; '1 is the saturation ceiling.
                            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                                if (PW'(p) == player_q &&
                                    scores_q[p*SCORE_W +: SCORE_W] != '1) begin
                                    scores_d[p*SCORE_W +: SCORE_W] =
                                        scores_q[p*SCORE_W +: SCORE_W] + SCORE_W'(1);
                                end
                            end
                        end else begin
                            start_pause_o = 1'b1;
                            state_d       = S_PAUSE;
                            pause_d       = CW'(PAUSE_CYCLES - 1);
                        end
                    end else if (timeout_ev) begin
                        tl_d = TW'(TURN_TICKS);
                    end else if (tick_i) begin
                        tl_d = tl_q - TW'(1);
                    end
                end
                S_PAUSE: begin
                    if (pause_q == '0) begin
                        end_turn_o = 1'b1;
                        player_d   = (player_q == PW'(NUM_PLAYERS - 1)) ? '0
                                                                        : player_q + PW'(1);
                        cnt_d      = '0;
                        tl_d       = TW'(TURN_TICKS);
                        state_d    = S_PICK;
                    end else begin
                        pause_d = pause_q - CW'(1);
                    end
                end
                S_OVER: begin
                    state_d = S_OVER;
                end
                default: begin
                    state_d = S_PICK;
                end
            endcase
        end
    end

    assign player_o    = player_q;
    assign time_left_o = tl_q;
    assign scores_o    = scores_q;
    assign state_o     = state_q;

endmodule
